// File: rtl/ser_arb_pkg.sv
// Shared types and helpers for the serializer arbiter.
// SER_ARB_RETRY_EN selects the retry-on-error build of ser_arbiter.
package ser_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIssue  = 2'd1,
        StXfer   = 2'd2,
        StRetire = 2'd3
    } arb_state_e;

    // Wide enough for any practical MAX_RETRY; checked at elaboration.
    localparam int unsigned RetryCntW = 4;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ser_arbiter_rr_pick.sv
// Combinational round-robin select: first set request at or after ptr, wrapping.
module rr_pick
    import ser_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IdW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IdW-1:0]  ptr,
    output logic [IdW-1:0]  gnt_id,
    output logic            any
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IdW-1:0]    off;
    logic [IdW:0]      sum;

    always_comb begin
        // Rotating the doubled vector puts requester ptr at bit 0.
        dbl = {req, req} >> ptr;
        rot = dbl[NREQ-1:0];
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IdW'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IdW + 1)'(NREQ)) begin
            sum = sum - (IdW + 1)'(NREQ);
        end
        gnt_id = sum[IdW-1:0];
    end

    assign any = |req;

endmodule

// File: rtl/ser_arbiter.sv
// Round-robin arbiter/sequencer sharing one MISO serializer among NREQ requesters.
// Define SER_ARB_RETRY_EN to reissue aborted transfers up to MAX_RETRY times.
module ser_arbiter
    import ser_arb_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned ADDRW     = 24,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*ADDRW-1:0]   req_addr,
    output logic [NREQ-1:0]         req_done,
    output logic [NREQ-1:0]         req_fail,
    output logic                    ser_valid,
    output logic [ADDRW-1:0]        ser_addr,
    input  logic                    ser_ready,
    input  logic                    ser_err,
    output logic                    busy,
    output logic [clog2(NREQ)-1:0]  grant_id
);

    localparam int unsigned IdW = clog2(NREQ);

    if (NREQ < 2) begin : g_bad_nreq
        $error("ser_arbiter: NREQ must be at least 2");
    end
    if (MAX_RETRY >= (1 << RetryCntW)) begin : g_bad_retry
        $error("ser_arbiter: MAX_RETRY does not fit the retry counter");
    end

    arb_state_e      state_q, state_d;
    logic [IdW-1:0]  grant_q, grant_d;
    logic [IdW-1:0]  ptr_q, ptr_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic            err_q, err_d;
    logic [IdW-1:0]  pick_id;
    logic            pick_any;
`ifdef SER_ARB_RETRY_EN
    logic [RetryCntW-1:0] cnt_q, cnt_d;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IdW  (IdW)
    ) u_rr_pick (
        .req    (req_valid),
        .ptr    (ptr_q),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        addr_d   = addr_q;
        err_d    = err_q;
`ifdef SER_ARB_RETRY_EN
        cnt_d    = cnt_q;
`endif
        req_done = '0;
        req_fail = '0;

        unique case (state_q)
            StIdle: begin
                // ser_ready guards against issuing over a transfer still shifting after reset.
                if (pick_any && ser_ready) begin
                    state_d = StIssue;
                    grant_d = pick_id;
                    addr_d  = req_addr[pick_id*ADDRW +: ADDRW];
`ifdef SER_ARB_RETRY_EN
                    cnt_d   = '0;
`endif
                end
            end
            StIssue: begin
                if (!ser_ready) begin
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (ser_ready) begin
                    err_d   = ser_err;
                    state_d = StRetire;
                end
            end
            StRetire: begin
                state_d = StIdle;
                ptr_d   = (grant_q == IdW'(NREQ - 1)) ? '0 : grant_q + IdW'(1);
                if (!err_q) begin
                    req_done[grant_q] = 1'b1;
                end else begin
`ifdef SER_ARB_RETRY_EN
                    if (cnt_q < RetryCntW'(MAX_RETRY)) begin
                        cnt_d   = cnt_q + RetryCntW'(1);
                        state_d = StIssue;
                        ptr_d   = ptr_q;
                    end else begin
                        req_fail[grant_q] = 1'b1;
                    end
`else
                    req_fail[grant_q] = 1'b1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

`ifdef SER_ARB_RETRY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign ser_valid = (state_q == StIssue);
    assign busy      = (state_q != StIdle);
    assign ser_addr  = addr_q;
    assign grant_id  = grant_q;

endmodule

// File: doc/ser_arbiter.md
# ser_arbiter

Round-robin arbiter and sequencer in front of the MISO `serializer`. It shares the single serializer among `NREQ` completion sources and drives the serializer's `valid_in`/`addr`/`ready_out`/`err` handshake. It reports per-requester completion or failure, and optionally retries transfers that the serializer aborted when `n_cs` rose mid-transfer.

## Interface
Parameters:
- `NREQ`, 4 — number of requesters, ≥2.
- `ADDRW`, 24 — address width; matches the serializer.
- `MAX_RETRY`, 3 — retries per transfer after a serializer `err`; used only with retry enabled.

Ports:
- `clk`  in  1  system clock; the serializer's `clk`.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  requester i has an address pending; held until its `req_done[i]` or `req_fail[i]`.
- `req_addr`  in  NREQ*ADDRW  flat address bus; slice i is `[i*ADDRW +: ADDRW]`.
- `req_done`  out  NREQ  one-cycle pulse: requester i's address fully shifted out.
- `req_fail`  out  NREQ  one-cycle pulse: requester i's transfer abandoned.
- `ser_valid`  out  1  to serializer `valid_in`.
- `ser_addr`  out  ADDRW  to serializer `addr`; registered.
- `ser_ready`  in  1  from serializer `ready_out`; 1 = idle.
- `ser_err`  in  1  from serializer `err`.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  clog2(NREQ)  index of the current or last granted requester.

## Operation
- FSM states:
  - IDLE: no transfer in progress.
  - ISSUE: `ser_valid` is high, waiting for the serializer to accept.
  - XFER: transfer in progress, waiting for the serializer to finish.
  - RETIRE: one cycle that emits the completion or failure pulse.
- IDLE → ISSUE: requires `|req_valid` and `ser_ready`=1.
  - The winner is the first set `req_valid` bit at or after `rr_ptr`, searching upward with wrap.
  - On the transition, latch `grant_id`, and copy the winner's address slice into `ser_addr`.
  - Clear the retry count.
- ISSUE: hold `ser_valid`=1 and `ser_addr` stable.
  - On `ser_ready`=0 (the serializer accepted): set `ser_valid`=0 and go to XFER.
  - There is no timeout; ISSUE waits indefinitely while `n_cs` is high.
- XFER: wait for `ser_ready`=1.
  - If `ser_err`=0 in that cycle, the outcome is done.
  - If `ser_err`=1 in that cycle, the outcome is err.
  - Either way, go to RETIRE.
- RETIRE:
  - Done: pulse `req_done[grant_id]`.
  - Err: handled per Configuration (retry or fail).
  - Completion (done or fail): set `rr_ptr` = `grant_id`+1, wrapping to 0 at NREQ, then go to IDLE.
- Requester changes to `req_valid`/`req_addr` after the grant are ignored until RETIRE, because the address is latched at grant.
- A requester whose `req_valid` drops while it is granted still gets its pulse.
- At most one bit of `req_done | req_fail` is set in any cycle.

## Timing
- Reset values:
  - `ser_valid`=0, `ser_addr`=0, `req_done`=0, `req_fail`=0, `busy`=0, `grant_id`=0.
  - `rr_ptr`=0, retry count=0, state IDLE.
- Reset mid-transfer:
  - Immediate return to IDLE, with no pulse for the interrupted requester.
  - The serializer may still be shifting. The IDLE guard `ser_ready`=1 prevents issuing on top of it.
- Grant latency: `ser_valid` rises one cycle after `req_valid` is sampled in IDLE.
- Acceptance timing: the serializer accepts only on an SPI-clock falling edge. ISSUE therefore lasts one or more cycles, set by the SPI clock period.
- Completion latency: the pulse is asserted one cycle after `ser_ready` rises.
  - The next grant is possible in the following cycle, giving a minimum of 2 `clk` cycles between transfers.
- `ser_err` is a one-cycle pulse coincident with `ser_ready` rising. It is sampled only in XFER.
- A `ser_ready` rise seen in ISSUE is impossible; ISSUE does not react to `ser_ready`=1.

## Configuration
- Macro `SER_ARB_RETRY_EN`, when defined:
  - On an err outcome with retry count < `MAX_RETRY`: increment the count, keep `grant_id` and `ser_addr`, go RETIRE → ISSUE, and emit no pulse.
  - Once the count equals `MAX_RETRY`: pulse `req_fail`.
- Without the macro:
  - Any err outcome pulses `req_fail[grant_id]` immediately.
  - The retry counter is not instantiated, and `MAX_RETRY` is unused.

## Structure
- Shared package `ser_arb_pkg`:
  - FSM state encoding: IDLE=0, ISSUE=1, XFER=2, RETIRE=3.
  - The `clog2` function.
  - A constant for the retry-counter width.
- One sub-module, `rr_pick`: combinational round-robin priority select.
  - Inputs: `req` [NREQ], `ptr`.
  - Outputs: `gnt_id`, `any`.
  - Implemented as a double-width rotate-and-find-first.

## Test plan
- Single request: `req_valid`=4'b0010, addr 0xABC123. Expect:
  - `ser_addr`=0xABC123 and `grant_id`=1.
  - `req_done`=4'b0010 one cycle after `ser_ready` rises; `busy` low the next cycle.
- All four requesting continuously → grant order 0,1,2,3,0. Each requester gets exactly one `req_done` per round.
- `ser_ready` held at 0 in IDLE while `req_valid`=4'b0001 → no grant and `ser_valid` stays 0. Grant issues one cycle after `ser_ready`=1.
- `ser_err` pulse at completion:
  - With `SER_ARB_RETRY_EN` and `MAX_RETRY`=3: three reissues of the same address, then on the 4th err a `req_fail` pulse.
  - Without the macro: `req_fail` on the first err.
- Assert `rst` during XFER → all outputs 0 asynchronously and no pulse. With `ser_ready` held 0 after reset, no new grant issues.
- `req_valid[2]` drops during XFER → `req_done[2]` still pulses, and `rr_ptr` advances to 3.
